// File: rtl/alu_uart_ctrl.sv
// Sequencer between a UART RX/TX pair and a registered ALU: gathers A, B, opcode, waits ALU_LAT cycles,
// then transmits the result byte followed by a flags byte {0.., overflow, zero}. One transaction at a time.
module alu_uart_ctrl #(
    parameter int N       = 8,
    parameter int NSel    = 6,
    parameter int ALU_LAT = 2
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [N-1:0]    i_rx_data,
    input  logic            i_rx_done,
    input  logic            i_tx_done,
    input  logic [N-1:0]    i_alu_Result,
    input  logic            i_overflow_Flag,
    input  logic            i_zero_Flag,
    output logic [N-1:0]    o_alu_A,
    output logic [N-1:0]    o_alu_B,
    output logic [NSel-1:0] o_alu_Op,
    output logic [N-1:0]    o_tx_data,
    output logic            o_tx_start,
    output logic            o_busy
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [2:0] GET_A    = 3'd0;
    localparam logic [2:0] GET_B    = 3'd1;
    localparam logic [2:0] GET_OP   = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] SEND_RES = 3'd4;
    localparam logic [2:0] WAIT_RES = 3'd5;
    localparam logic [2:0] SEND_FLG = 3'd6;
    localparam logic [2:0] WAIT_FLG = 3'd7;

    logic [2:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_alu_a;
    logic [N-1:0]    r_alu_b;
    logic [NSel-1:0] r_alu_op;
    logic [N-1:0]    r_res;
    logic [1:0]      r_flg;
    logic [N-1:0]    r_tx_data;
    logic            r_tx_start;
    logic            w_lat_done;

    assign w_lat_done = (r_cnt == CW'(ALU_LAT - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= GET_A;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_res      <= '0;
            r_flg      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            // start is a single-cycle pulse; only the SEND states raise it
            r_tx_start <= 1'b0;
            case (r_state)
                GET_A: if (i_rx_done) begin
                    r_alu_a <= i_rx_data;
                    r_state <= GET_B;
                end
                GET_B: if (i_rx_done) begin
                    r_alu_b <= i_rx_data;
                    r_state <= GET_OP;
                end
                GET_OP: if (i_rx_done) begin
                    r_alu_op <= i_rx_data[NSel-1:0];
                    r_cnt    <= '0;
                    r_state  <= EXEC;
                end
                EXEC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_lat_done) begin
                        r_res   <= i_alu_Result;
                        r_flg   <= {i_overflow_Flag, i_zero_Flag};
                        r_state <= SEND_RES;
                    end
                end
                SEND_RES: begin
                    r_tx_data  <= r_res;
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT_RES;
                end
                WAIT_RES: if (i_tx_done) r_state <= SEND_FLG;
                SEND_FLG: begin
                    r_tx_data  <= {{(N-2){1'b0}}, r_flg};
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT_FLG;
                end
                WAIT_FLG: if (i_tx_done) r_state <= GET_A;
                default: begin
                    r_state    <= GET_A;
                    r_cnt      <= '0;
                    r_alu_a    <= '0;
                    r_alu_b    <= '0;
                    r_alu_op   <= '0;
                    r_res      <= '0;
                    r_flg      <= '0;
                    r_tx_data  <= '0;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

    assign o_alu_A    = r_alu_a;
    assign o_alu_B    = r_alu_b;
    assign o_alu_Op   = r_alu_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = (r_state != GET_A);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Bench for alu_uart_ctrl: registered ALU model, directed transactions, TX bytes checked by a queue-based monitor.
module tb_alu_uart_ctrl;

    localparam int N       = 8;
    localparam int NSel    = 6;
    localparam int ALU_LAT = 2;
    localparam int LIM     = 200;

    logic            i_clock = 1'b0;
    logic            i_reset = 1'b1;
    logic [N-1:0]    i_rx_data = '0;
    logic            i_rx_done = 1'b0;
    logic            i_tx_done = 1'b0;
    logic [N-1:0]    i_alu_Result;
    logic            i_overflow_Flag;
    logic            i_zero_Flag;
    logic [N-1:0]    o_alu_A;
    logic [N-1:0]    o_alu_B;
    logic [NSel-1:0] o_alu_Op;
    logic [N-1:0]    o_tx_data;
    logic            o_tx_start;
    logic            o_busy;

    int n_pass   = 0;
    int n_checks = 0;
    logic [7:0] exp_q[$];
    logic       prev_start = 1'b0;

    alu_uart_ctrl #(.N(N), .NSel(NSel), .ALU_LAT(ALU_LAT)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
        .i_alu_Result(i_alu_Result), .i_overflow_Flag(i_overflow_Flag), .i_zero_Flag(i_zero_Flag),
        .o_alu_A(o_alu_A), .o_alu_B(o_alu_B), .o_alu_Op(o_alu_Op),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    // ALU model: ADD 0x20, SUB 0x22, AND 0x24, all registered one cycle after the inputs
    always @(posedge i_clock) begin
        logic [N-1:0] r;
        logic         v;
        r = '0;
        v = 1'b0;
        case (o_alu_Op)
            6'h20: begin
                r = o_alu_A + o_alu_B;
                v = (o_alu_A[N-1] == o_alu_B[N-1]) && (r[N-1] != o_alu_A[N-1]);
            end
            6'h22: begin
                r = o_alu_A - o_alu_B;
                v = (o_alu_A[N-1] != o_alu_B[N-1]) && (r[N-1] != o_alu_A[N-1]);
            end
            6'h24: r = o_alu_A & o_alu_B;
            default: r = '0;
        endcase
        i_alu_Result    <= r;
        i_overflow_Flag <= v;
        i_zero_Flag     <= (r == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge i_clock) begin
        if (!i_reset && o_tx_start) begin
            check("tx_start_gap", {31'd0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got byte 0x%0h with no byte expected", o_tx_data);
            end else begin
                check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_start = o_tx_start;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_A"},     {24'd0, o_alu_A}, 32'd0);
        check({tag, "_B"},     {24'd0, o_alu_B}, 32'd0);
        check({tag, "_Op"},    {26'd0, o_alu_Op}, 32'd0);
        check({tag, "_txd"},   {24'd0, o_tx_data}, 32'd0);
        check({tag, "_start"}, {31'd0, o_tx_start}, 32'd0);
        check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clock);
        i_rx_done = 1'b0;
    endtask

    // mode 0: plain, 1: stray rx/tx pulses during EXEC/SEND/WAIT, 2: stall in WAIT_RES then reset
    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input logic [5:0] exp_op, input logic [7:0] res, input logic [7:0] flg,
                       input int mode);
        int cnt;
        bit held;
        exp_q.push_back(res);
        if (mode != 2) exp_q.push_back(flg);
        send_byte(a);
        check("busy_after_A", {31'd0, o_busy}, 32'd1);
        send_byte(b);
        send_byte(opb);
        check("alu_A",  {24'd0, o_alu_A}, {24'd0, a});
        check("alu_B",  {24'd0, o_alu_B}, {24'd0, b});
        check("alu_Op", {26'd0, o_alu_Op}, {26'd0, exp_op});
        cnt = 0;
        while (!o_tx_start && cnt < LIM) begin
            if (mode == 1) begin
                i_rx_data = 8'hAA;
                i_rx_done = (cnt == 0);
                i_tx_done = (cnt == 2);
            end
            @(negedge i_clock);
            cnt++;
        end
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("start_latency", cnt, ALU_LAT + 1);
        if (mode == 1) send_byte(8'hAA);
        if (mode == 2) begin
            held = 1'b1;
            repeat (50) begin
                @(negedge i_clock);
                if (o_tx_start || o_tx_data !== res) held = 1'b0;
            end
            check("hold_wait_res", {31'd0, held}, 32'd1);
            i_reset = 1'b1;
            @(negedge i_clock);
            i_reset = 1'b0;
            check_idle_outputs("midreset");
            return;
        end
        repeat (2) @(negedge i_clock);
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
        cnt = 0;
        while (!o_tx_start && cnt < LIM) begin
            @(negedge i_clock);
            cnt++;
        end
        check("flg_start_seen", {31'd0, o_tx_start}, 32'd1);
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
        check("idle_after_txn", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge i_clock);
        check_idle_outputs("reset");
        i_reset = 1'b0;
        @(negedge i_clock);
        check("idle_after_reset", {31'd0, o_busy}, 32'd0);

        txn(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00, 0);
        txn(8'h7F, 8'h01, 8'h20, 6'h20, 8'h80, 8'h02, 0);
        txn(8'h05, 8'h05, 8'h22, 6'h22, 8'h00, 8'h01, 0);
        txn(8'h0F, 8'h3C, 8'hE4, 6'h24, 8'h0C, 8'h00, 0);
        txn(8'h11, 8'h22, 8'h20, 6'h20, 8'h33, 8'h00, 1);
        txn(8'h0A, 8'h0B, 8'h20, 6'h20, 8'h15, 8'h00, 0);
        txn(8'h01, 8'h01, 8'h20, 6'h20, 8'h02, 8'h00, 2);
        txn(8'h80, 8'h01, 8'h22, 6'h22, 8'h7F, 8'h02, 0);

        repeat (3) @(negedge i_clock);
        check("tx_bytes_left", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
